// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction codes, FSM states and segment count width for snake_mover
package snake_pkg;

   localparam logic [2:0] DIR_LEFT  = 3'b000;
   localparam logic [2:0] DIR_RIGHT = 3'b001;
   localparam logic [2:0] DIR_UP    = 3'b100;
   localparam logic [2:0] DIR_DOWN  = 3'b110;

   localparam int SEG_CNT_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      CHECK,
      DRAW_HEAD,
      ERASE_TAIL,
      DEAD
   } state_t;

endpackage

// File: rtl/game_tick_gen.sv
// rtl/game_tick_gen.sv - free-running game tick divider, frozen while enable is low
module game_tick_gen #(
   parameter int TICK_DIV = 2500000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/snake_mover.sv
// rtl/snake_mover.sv - advances the snake per tick, scans for self-collision and
// requests head paint / tail erase from the drawer
module snake_mover
   import snake_pkg::*;
#(
   parameter int GRID_W    = 160,
   parameter int GRID_H    = 120,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int TICK_DIV  = 2500000,
   parameter int MAX_LEN   = 16,
   parameter int START_X   = 80,
   parameter int START_Y   = 60,
   parameter int START_LEN = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           dir_in,
   input  logic                 dir_valid,
   input  logic                 enable,
   input  logic                 grow,
   output logic [X_W-1:0]       head_x,
   output logic [Y_W-1:0]       head_y,
   output logic [SEG_CNT_W-1:0] length,
   output logic                 draw_req,
   input  logic                 draw_ack,
   output logic [X_W-1:0]       draw_x,
   output logic [Y_W-1:0]       draw_y,
   output logic                 draw_erase,
   output logic                 collide,
   output logic                 busy
);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam logic [X_W-1:0]       X_MAX   = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0]       Y_MAX   = Y_W'(GRID_H - 1);
   localparam logic [SEG_CNT_W-1:0] LEN_MAX = SEG_CNT_W'(MAX_LEN);

   state_t               state, state_nx;
   logic [X_W-1:0]       seg_x [MAX_LEN];
   logic [Y_W-1:0]       seg_y [MAX_LEN];
   logic [SEG_CNT_W-1:0] len;
   logic [2:0]           pend_dir;
   logic                 grow_pending, grew;
   logic [X_W-1:0]       tail_x, nx;
   logic [Y_W-1:0]       tail_y, ny;
   logic [IDX_W-1:0]     chk_idx, tail_idx;
   logic                 tick, hit, chk_last;

   game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (enable && !collide),
      .tick   (tick)
   );

   assign tail_idx = IDX_W'(len - 1'b1);
   assign chk_last = (chk_idx == tail_idx);
   assign hit      = (seg_x[chk_idx] == seg_x[0]) && (seg_y[chk_idx] == seg_y[0]);
   assign head_x   = seg_x[0];
   assign head_y   = seg_y[0];
   assign length   = len;
   assign busy     = (state != IDLE);

   // Next head with toroidal wrap; bit 0 is ignored for vertical codes
   always_comb begin
      nx = seg_x[0];
      ny = seg_y[0];
      if (pend_dir[2]) begin
         if (pend_dir[1]) ny = (seg_y[0] == Y_MAX) ? '0 : seg_y[0] + 1'b1;
         else             ny = (seg_y[0] == '0) ? Y_MAX : seg_y[0] - 1'b1;
      end else begin
         if (pend_dir[0]) nx = (seg_x[0] == X_MAX) ? '0 : seg_x[0] + 1'b1;
         else             nx = (seg_x[0] == '0) ? X_MAX : seg_x[0] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (tick) state_nx = MOVE;
         MOVE:       state_nx = CHECK;
         CHECK:      if (hit) state_nx = DEAD;
                     else if (chk_last) state_nx = DRAW_HEAD;
         DRAW_HEAD:  if (draw_ack) state_nx = grew ? IDLE : ERASE_TAIL;
         ERASE_TAIL: if (draw_ack && draw_req) state_nx = IDLE;
         DEAD:       state_nx = DEAD;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < START_LEN) ? X_W'(START_X + i) : '0;
            seg_y[i] <= (i < START_LEN) ? Y_W'(START_Y) : '0;
         end
         len          <= SEG_CNT_W'(START_LEN);
         pend_dir     <= DIR_LEFT;
         grow_pending <= 1'b0;
         grew         <= 1'b0;
         tail_x       <= '0;
         tail_y       <= '0;
         chk_idx      <= '0;
         collide      <= 1'b0;
         draw_req     <= 1'b0;
         draw_x       <= '0;
         draw_y       <= '0;
         draw_erase   <= 1'b0;
      end else begin
         if (dir_valid) pend_dir <= dir_in;
         if (grow) grow_pending <= 1'b1;
         case (state)
            MOVE: begin
               tail_x <= seg_x[tail_idx];
               tail_y <= seg_y[tail_idx];
               for (int k = MAX_LEN - 1; k > 0; k--) begin
                  seg_x[k] <= seg_x[k-1];
                  seg_y[k] <= seg_y[k-1];
               end
               seg_x[0]     <= nx;
               seg_y[0]     <= ny;
               grow_pending <= 1'b0;
               if ((grow_pending || grow) && (len < LEN_MAX)) begin
                  len  <= len + 1'b1;
                  grew <= 1'b1;
               end else begin
                  grew <= 1'b0;
               end
               chk_idx <= IDX_W'(1);
            end
            CHECK: begin
               if (hit) begin
                  collide <= 1'b1;
               end else if (!chk_last) begin
                  chk_idx <= chk_idx + 1'b1;
               end else begin
                  draw_req   <= 1'b1;
                  draw_x     <= seg_x[0];
                  draw_y     <= seg_y[0];
                  draw_erase <= 1'b0;
               end
            end
            DRAW_HEAD: if (draw_ack) draw_req <= 1'b0;
            // Erase request goes up one cycle after the head ack; draw_erase marks it sent
            ERASE_TAIL: begin
               if (draw_req) begin
                  if (draw_ack) draw_req <= 1'b0;
               end else if (!draw_erase) begin
                  draw_req   <= 1'b1;
                  draw_x     <= tail_x;
                  draw_y     <= tail_y;
                  draw_erase <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
